// File: rtl/bictr_seq_ctrl_if.sv
// Control bus between the segment sequencer and the up/down counter with count-to flag.
// The master side (sequencer) drives load/step controls; the counter returns tercnt/count.
interface bictr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] count_to;
  logic             up_dn;
  logic             load_n;
  logic             cen;
  logic             tercnt;
  logic [WIDTH-1:0] count;

  modport master (
    output data, count_to, up_dn, load_n, cen,
    input  tercnt, count
  );

  modport slave (
    input  data, count_to, up_dn, load_n, cen,
    output tercnt, count
  );
endinterface

// File: rtl/bictr_seq_ctrl.sv
// Segment sequencer: walks an up/down counter through programmed target/direction ramps.
// Define BICTR_SEQ_DWELL_EN to add a per-segment dwell (HOLD state, prog_dwell, hold_active).
module bictr_seq_ctrl #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [WIDTH-1:0] prog_target,
  input  logic             prog_dir,
`ifdef BICTR_SEQ_DWELL_EN
  input  logic [7:0]       prog_dwell,
  output logic             hold_active,
`endif
  output logic             prog_err,
  input  logic [AW-1:0]    seg_last,
  input  logic [WIDTH-1:0] start_val,
  input  logic             loop_en,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    seg_idx,
  bictr_seq_ctrl_if.master ctr
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StNext,
    StDone
`ifdef BICTR_SEQ_DWELL_EN
    , StHold
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    seg_idx_q, seg_idx_d, seg_last_q, seg_last_d, nxt_idx;
  logic [WIDTH-1:0] data_q, data_d, count_to_q, count_to_d;
  logic             up_dn_q, up_dn_d, prog_err_q;
  logic [WIDTH-1:0] tgt_q [DEPTH];
  logic             dir_q [DEPTH];
`ifdef BICTR_SEQ_DWELL_EN
  logic [7:0]       dwell_q [DEPTH];
  logic [7:0]       hold_cnt_q, hold_cnt_d;
`endif

  // Slots are only writable while idle so a running sequence sees a stable table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i] <= '0;
        dir_q[i] <= 1'b0;
`ifdef BICTR_SEQ_DWELL_EN
        dwell_q[i] <= '0;
`endif
      end
    end else if (prog_we && (state_q == StIdle)) begin
      tgt_q[prog_addr] <= prog_target;
      dir_q[prog_addr] <= prog_dir;
`ifdef BICTR_SEQ_DWELL_EN
      dwell_q[prog_addr] <= prog_dwell;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    seg_idx_d  = seg_idx_q;
    seg_last_d = seg_last_q;
    data_d     = data_q;
    count_to_d = count_to_q;
    up_dn_d    = up_dn_q;
    nxt_idx    = seg_idx_q + AW'(1);
`ifdef BICTR_SEQ_DWELL_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            data_d     = start_val;
            seg_last_d = seg_last;
            seg_idx_d  = '0;
            count_to_d = tgt_q[0];
            up_dn_d    = dir_q[0];
            state_d    = StLoad;
          end
        end
        StLoad: state_d = StRun;
        StRun: begin
          if (ctr.tercnt) begin
`ifdef BICTR_SEQ_DWELL_EN
            if (dwell_q[seg_idx_q] != 8'd0) begin
              hold_cnt_d = dwell_q[seg_idx_q];
              state_d    = StHold;
            end else begin
              state_d = StNext;
            end
`else
            state_d = StNext;
`endif
          end
        end
`ifdef BICTR_SEQ_DWELL_EN
        StHold: begin
          hold_cnt_d = hold_cnt_q - 8'd1;
          if (hold_cnt_q == 8'd1) state_d = StNext;
        end
`endif
        StNext: begin
          if (seg_idx_q != seg_last_q) begin
            seg_idx_d  = nxt_idx;
            count_to_d = tgt_q[nxt_idx];
            up_dn_d    = dir_q[nxt_idx];
            state_d    = StRun;
          end else begin
            state_d = StDone;
          end
        end
        StDone: begin
          // Looping resumes from the counter's current value; no reload.
          if (loop_en) begin
            seg_idx_d  = '0;
            count_to_d = tgt_q[0];
            up_dn_d    = dir_q[0];
            state_d    = StRun;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      seg_idx_q  <= '0;
      seg_last_q <= '0;
      data_q     <= '0;
      count_to_q <= '0;
      up_dn_q    <= 1'b1;
      prog_err_q <= 1'b0;
`ifdef BICTR_SEQ_DWELL_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seg_idx_q  <= seg_idx_d;
      seg_last_q <= seg_last_d;
      data_q     <= data_d;
      count_to_q <= count_to_d;
      up_dn_q    <= up_dn_d;
      prog_err_q <= prog_we & (state_q != StIdle);
`ifdef BICTR_SEQ_DWELL_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // cen follows tercnt combinationally so the counter stops exactly on the target.
  always_comb begin
    ctr.load_n = 1'b1;
    ctr.cen    = 1'b0;
    if (state_q == StLoad) ctr.load_n = 1'b0;
    if (state_q == StRun)  ctr.cen    = ~ctr.tercnt;
  end

  assign ctr.data     = data_q;
  assign ctr.count_to = count_to_q;
  assign ctr.up_dn    = up_dn_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign seg_idx      = seg_idx_q;
  assign prog_err     = prog_err_q;
`ifdef BICTR_SEQ_DWELL_EN
  assign hold_active  = (state_q == StHold);
`endif

endmodule

// File: tb/tb_bictr_seq_ctrl.sv
// Bench for bictr_seq_ctrl: behavioural counter plus a per-cycle expected-trace scoreboard.
// Build with BICTR_SEQ_DWELL_EN defined to also exercise the dwell/HOLD feature.
module tb_bictr_seq_ctrl;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we, prog_dir, prog_err, loop_en, start, abort, busy, done;
  logic [AW-1:0] prog_addr, seg_last, seg_idx;
  logic [W-1:0]  prog_target, start_val;
`ifdef BICTR_SEQ_DWELL_EN
  logic [7:0]    prog_dwell;
  logic          hold_active;
`endif

  bictr_seq_ctrl_if #(.WIDTH(W)) ctr ();

  bictr_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_target(prog_target),
    .prog_dir   (prog_dir),
`ifdef BICTR_SEQ_DWELL_EN
    .prog_dwell (prog_dwell),
    .hold_active(hold_active),
`endif
    .prog_err   (prog_err),
    .seg_last   (seg_last),
    .start_val  (start_val),
    .loop_en    (loop_en),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .seg_idx    (seg_idx),
    .ctr        (ctr)
  );

  always #5 clk = ~clk;

  // Downstream counter: active-low load, count enable, tercnt when count equals count_to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ctr.count <= '0;
    else if (!ctr.load_n)   ctr.count <= ctr.data;
    else if (ctr.cen)       ctr.count <= ctr.up_dn ? ctr.count + 8'd1 : ctr.count - 8'd1;
  end
  assign ctr.tercnt = (ctr.count == ctr.count_to);

  typedef struct {
    logic busy, done, load_n, cen, up_dn, prog_err, hold, chk_cnt, chk_seg;
    logic [AW-1:0] idx;
    logic [W-1:0]  count_to, count, data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         idle_e;
  logic [W-1:0] m_tgt [D];
  logic         m_dir [D];
  int           m_dwell [D];
  int n_chk = 0, n_fail = 0, cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, hold_seen = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t rec(input bit b, input bit d, input bit ln, input bit ce, input bit hd,
                               input int idx, input logic [W-1:0] cnt, input bit cc);
    exp_t e;
    e.busy = b; e.done = d; e.load_n = ln; e.cen = ce; e.hold = hd; e.prog_err = 1'b0;
    e.chk_seg = b; e.chk_cnt = cc; e.idx = AW'(idx); e.count = cnt; e.data = '0;
    e.count_to = m_tgt[idx]; e.up_dn = m_dir[idx];
    return e;
  endfunction

  // Expected per-cycle trace from the segment list: LOAD, then per segment |distance|+1 RUN
  // cycles (cen high on all but the last), dwell HOLD cycles, one NEXT; DONE after the last.
  task automatic gen(input int last, input logic [W-1:0] sv, input int passes);
    logic [W-1:0] cur, diff;
    exp_t e;
    int steps;
    cur = sv;
    e = rec(1, 0, 0, 0, 0, 0, '0, 0);
    e.data = sv;
    exp_q.push_back(e);
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s <= last; s++) begin
        diff  = m_dir[s] ? m_tgt[s] - cur : cur - m_tgt[s];
        steps = int'(diff);
        for (int k = 0; k <= steps; k++) begin
          exp_q.push_back(rec(1, 0, 1, k < steps, 0, s, cur, 1));
          if (k < steps) cur = m_dir[s] ? cur + 8'd1 : cur - 8'd1;
        end
        for (int h = 0; h < m_dwell[s]; h++) exp_q.push_back(rec(1, 0, 1, 0, 1, s, cur, 1));
        exp_q.push_back(rec(1, 0, 1, 0, 0, s, cur, 1));
        if (s == last) exp_q.push_back(rec(1, 1, 1, 0, 0, s, cur, 1));
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e;
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("ctr_load_n", ctr.load_n, e.load_n);
      chk("ctr_cen", ctr.cen, e.cen);
      chk("prog_err", prog_err, e.prog_err);
`ifdef BICTR_SEQ_DWELL_EN
      chk("hold_active", hold_active, e.hold);
      if (hold_active) hold_seen++;
`endif
      if (e.chk_seg) begin
        chk("seg_idx", seg_idx, e.idx);
        chk("ctr_count_to", ctr.count_to, e.count_to);
        chk("ctr_up_dn", ctr.up_dn, e.up_dn);
      end
      if (!e.load_n) chk("ctr_data", ctr.data, e.data);
      if (e.chk_cnt) chk("count", ctr.count, e.count);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic prog(input int a, input logic [W-1:0] t, input logic d, input int dw);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = AW'(a); prog_target = t; prog_dir = d;
`ifdef BICTR_SEQ_DWELL_EN
    prog_dwell = 8'(dw);
    m_dwell[a] = dw;
`endif
    @(posedge clk); #1;
    prog_we = 1'b0;
    m_tgt[a] = t;
    m_dir[a] = d;
  endtask

  task automatic run(input int last, input logic [W-1:0] sv, input bit lp, input int passes);
    @(posedge clk); #1;
    seg_last = AW'(last); start_val = sv; loop_en = lp; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    gen(last, sv, passes);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= budget, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_prog_err"}, prog_err, 0);
    chk({tag, "_seg_idx"}, seg_idx, 0);
    chk({tag, "_load_n"}, ctr.load_n, 1);
    chk({tag, "_cen"}, ctr.cen, 0);
    chk({tag, "_data"}, ctr.data, 0);
    chk({tag, "_count_to"}, ctr.count_to, 0);
    chk({tag, "_up_dn"}, ctr.up_dn, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    idle_e = '{busy: 0, done: 0, load_n: 1, cen: 0, up_dn: 1, prog_err: 0, hold: 0,
               chk_cnt: 0, chk_seg: 0, idx: '0, count_to: '0, count: '0, data: '0};
    for (int i = 0; i < D; i++) begin
      m_tgt[i] = '0; m_dir[i] = 1'b0; m_dwell[i] = 0;
    end
    reset = 1'b1; prog_we = 0; prog_addr = '0; prog_target = '0; prog_dir = 0;
    seg_last = '0; start_val = '0; loop_en = 0; start = 0; abort = 0;
`ifdef BICTR_SEQ_DWELL_EN
    prog_dwell = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_checks("in_reset");
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    reset_checks("after_reset");

    // Two-segment ramp 0 -> 4 up, then 4 -> 1 down.
    prog(0, 8'h04, 1'b1, 0);
    prog(1, 8'h01, 1'b0, 0);
    snap = done_cnt;
    run(1, 8'h00, 1'b0, 1);
    drain(200);
    chk("ramp_done_latency", done_cyc - start_cyc, 13);
    chk("ramp_done_count", done_cnt - snap, 1);

    // Abort while counting 1 -> 2, with a dropped write to slot 0 in the same cycle.
    snap = done_cnt;
    run(1, 8'h00, 1'b0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_target = 8'h77; prog_dir = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; prog_we = 1'b0;
    exp_q.delete();
    begin
      exp_t e;
      e = idle_e; e.chk_cnt = 1; e.count = 8'h02; e.prog_err = 1'b1;
      exp_q.push_back(e);
      e.prog_err = 1'b0;
      repeat (3) exp_q.push_back(e);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - snap, 0);

    // Rerun from 2: slot 0 must still target 4 up.
    run(1, 8'h02, 1'b0, 1);
    drain(200);

    // start and abort together: abort wins, stay idle.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);

    // Target equals start value: RUN is a single cycle with cen low.
    prog(0, 8'h00, 1'b1, 0);
    run(0, 8'h00, 1'b0, 1);
    drain(50);
    chk("zero_len_done_latency", done_cyc - start_cyc, 4);

    // Up ramp wrapping through 0xFF -> 0x00.
    prog(0, 8'h02, 1'b1, 0);
    run(0, 8'hFE, 1'b0, 1);
    drain(50);
    chk("wrap_done_latency", done_cyc - start_cyc, 8);

    // Looping run: second pass starts with no reload, loop_en dropped after first done.
    prog(0, 8'h02, 1'b0, 0);
    snap = done_cnt;
    run(0, 8'h03, 1'b1, 2);
    begin
      int n = 0;
      while (!done && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("loop_first_done_timeout", n >= 50, 0);
    end
    @(posedge clk); #1;
    loop_en = 1'b0;
    drain(50);
    chk("loop_done_count", done_cnt - snap, 2);

    // Asynchronous reset mid-sequence, then confirm the slot RAM was cleared.
    prog(0, 8'h40, 1'b1, 0);
    run(0, 8'h00, 1'b0, 1);
    repeat (4) @(posedge clk);
    #3;
    chk_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    #1;
    reset_checks("async_reset");
    for (int i = 0; i < D; i++) begin
      m_tgt[i] = '0; m_dir[i] = 1'b0; m_dwell[i] = 0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    run(0, 8'h05, 1'b0, 1);
    drain(50);

`ifdef BICTR_SEQ_DWELL_EN
    // Dwell 5 at 3 after ramping up, then straight down to 0 with no HOLD.
    prog(0, 8'h03, 1'b1, 5);
    prog(1, 8'h00, 1'b0, 0);
    hold_seen = 0;
    run(1, 8'h00, 1'b0, 1);
    drain(100);
    chk("dwell_hold_cycles", hold_seen, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
